// File: rtl/vmips_enc_pkg.sv
// Shared definitions for the vector-instruction encoder: op codes, FSM
// states, instruction format tags and function-field constants.
package vmips_enc_pkg;

  typedef enum logic [2:0] {
    OP_ADDVI   = 3'd0,
    OP_SUBVI   = 3'd1,
    OP_LD      = 3'd2,
    OP_ST      = 3'd3,
    OP_LDI     = 3'd4,
    OP_ADDV    = 3'd5,
    OP_SUBV    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } enc_state_e;

  // Format tags occupying word[29:26]
  localparam logic [3:0] FMT_I5  = 4'b0001;
  localparam logic [3:0] FMT_MEM = 4'b1000;
  localparam logic [3:0] FMT_LDI = 4'b0010;
  localparam logic [3:0] FMT_R   = 4'b0100;

  // Function fields
  localparam logic [5:0] FUNCT_I5  = 6'b000110;
  localparam logic [5:0] FUNCT_R   = 6'b001110;
  localparam logic [3:0] FUNCT_LD  = 4'b1000;
  localparam logic [3:0] FUNCT_ST  = 4'b1001;
  localparam logic [2:0] FUNCT_LDI = 3'b110;

endpackage

// File: rtl/vinst_pack.sv
// Combinational packing of one op into a 32-bit instruction word.
// Optional macro ENC_RANGE_CHECK_EN: reject 5-bit-immediate ops whose
// immediate does not fit in op_imm[4:0] instead of truncating it.
module vinst_pack
  import vmips_enc_pkg::*;
(
  input  logic [2:0]  op_code,
  input  logic [4:0]  op_rd,
  input  logic [4:0]  op_rs,
  input  logic [4:0]  op_rt,
  input  logic [9:0]  op_imm,
  output logic [31:0] word,
  output logic        legal
);

  // Field placement per format; every bit not named stays zero
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_code)
      OP_ADDVI, OP_SUBVI: begin
        word[29:26] = FMT_I5;
        word[25:23] = (op_code == OP_SUBVI) ? 3'b001 : 3'b000;
        word[20:16] = op_imm[4:0];
        word[15:11] = op_rs;
        word[10:6]  = op_rd;
        word[5:0]   = FUNCT_I5;
`ifdef ENC_RANGE_CHECK_EN
        if (op_imm[9:5] != 5'd0) legal = 1'b0;
`endif
      end
      OP_LD, OP_ST: begin
        word[29:26] = FMT_MEM;
        word[25:16] = op_imm;
        word[15:11] = op_rs;
        word[10:6]  = (op_code == OP_LD) ? op_rd : op_rt;
        word[5:2]   = (op_code == OP_LD) ? FUNCT_LD : FUNCT_ST;
      end
      OP_LDI: begin
        word[29:26] = FMT_LDI;
        word[25:23] = FUNCT_LDI;
        word[20:11] = op_imm;
        word[10:6]  = op_rd;
      end
      OP_ADDV, OP_SUBV: begin
        word[29:26] = FMT_R;
        word[25:23] = (op_code == OP_SUBV) ? 3'b001 : 3'b000;
        word[20:16] = op_rt;
        word[15:11] = op_rs;
        word[10:6]  = op_rd;
        word[5:0]   = FUNCT_R;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vinst_encoder.sv
// Session-based instruction encoder: accepts a stream of ops after a start
// pulse and writes packed words to consecutive instruction-memory addresses.
// Optional macro ENC_RANGE_CHECK_EN (handled in vinst_pack).
module vinst_encoder
  import vmips_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_last,
  input  logic [2:0]  op_code,
  input  logic [4:0]  op_rd,
  input  logic [4:0]  op_rs,
  input  logic [4:0]  op_rt,
  input  logic [9:0]  op_imm,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  inst_count
);

  enc_state_e  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        end_pend_q, end_pend_d;
  logic        we_q, we_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] pack_word;
  logic        pack_legal;

  vinst_pack u_pack (
    .op_code (op_code),
    .op_rd   (op_rd),
    .op_rs   (op_rs),
    .op_rt   (op_rt),
    .op_imm  (op_imm),
    .word    (pack_word),
    .legal   (pack_legal)
  );

  // Next-state, counters and write-port register inputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    end_pend_d = end_pend_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          addr_d     = base_addr;
          cnt_d      = '0;
          err_d      = 1'b0;
          end_pend_d = 1'b0;
        end
      end
      S_LOAD: begin
        // A session end raised by a written op waits one cycle so its write
        // drains before DONE; skipped ops have no write to wait for.
        if (end_pend_q) begin
          state_d    = S_DONE;
          end_pend_d = 1'b0;
        end else if (op_valid) begin
          if (pack_legal) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = pack_word;
            addr_d  = addr_q + 8'd1;
            cnt_d   = cnt_q + 9'd1;
            if (addr_q == 8'hFF) begin
              err_d      = 1'b1;
              end_pend_d = 1'b1;
            end
            if (op_last) end_pend_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (op_last) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      end_pend_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      end_pend_q <= end_pend_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign op_ready   = (state_q == S_LOAD) && !end_pend_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign inst_count = cnt_q;
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_vinst_encoder.sv
// Self-checking bench for vinst_encoder: a word-level reference model checks
// every write, err and inst_count each cycle; directed sessions pin literals.
module tb_vinst_encoder;

  logic        clk = 1'b0;
  logic        rst, start, op_valid, op_last;
  logic [7:0]  base_addr;
  logic [2:0]  op_code;
  logic [4:0]  op_rd, op_rs, op_rt;
  logic [9:0]  op_imm;
  logic        op_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  inst_count;

  vinst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .op_valid(op_valid), .op_ready(op_ready), .op_last(op_last),
    .op_code(op_code), .op_rd(op_rd), .op_rs(op_rs), .op_rt(op_rt),
    .op_imm(op_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoding built directly from the field layout
  function automatic logic [31:0] model_word(input int unsigned code, rd, rs, rt, imm);
    int unsigned w;
    case (code)
      0, 1:    w = (1 << 26) | (code << 23) | ((imm % 32) << 16) | (rs << 11) | (rd << 6) | 6;
      2:       w = (8 << 26) | (imm << 16) | (rs << 11) | (rd << 6) | (8 << 2);
      3:       w = (8 << 26) | (imm << 16) | (rs << 11) | (rt << 6) | (9 << 2);
      4:       w = (2 << 26) | (6 << 23) | (imm << 11) | (rd << 6);
      5, 6:    w = (4 << 26) | ((code - 5) << 23) | (rt << 16) | (rs << 11) | (rd << 6) | 14;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit model_legal(input int unsigned code, imm);
    if (code == 7) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    if (code <= 1 && imm >= 32) return 1'b0;
`endif
    return 1'b1;
  endfunction

  typedef struct { logic [7:0] addr; logic [31:0] data; int unsigned cyc; } wr_t;
  wr_t         wlog[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_snap = 0;

  // Model state, advanced one step per cycle from the sampled inputs
  bit          chk_en = 0, prev_rst = 0, exp_we = 0, m_err = 0;
  logic [7:0]  exp_addr, m_addr = '0;
  logic [31:0] exp_data;
  int unsigned m_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
      if (exp_we) begin
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
        chk("imem_wdata", imem_wdata, exp_data);
      end
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("inst_count", {23'd0, inst_count}, m_cnt);
      if (prev_rst) begin
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_flags", {28'd0, busy, done, op_ready, imem_we}, 32'd0);
      end
    end
    if (imem_we) wlog.push_back('{imem_addr, imem_wdata, cyc});
    if (done) done_cnt++;
    exp_we   = 1'b0;
    prev_rst = rst;
    if (rst) begin
      chk_en = 1'b1;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else if (start && !busy) begin
      m_addr = base_addr;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else if (op_valid && op_ready) begin
      if (model_legal(op_code, op_imm)) begin
        exp_we   = 1'b1;
        exp_addr = m_addr;
        exp_data = model_word(op_code, op_rd, op_rs, op_rt, op_imm);
        if (m_addr == 8'hFF) m_err = 1'b1;
        m_addr = m_addr + 8'd1;
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    wlog.delete();
    done_snap = done_cnt;
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_op(input int unsigned code, rd, rs, rt, imm, input bit last, output bit acc);
    op_valid = 1'b1; op_code = 3'(code); op_rd = 5'(rd); op_rs = 5'(rs);
    op_rt = 5'(rt); op_imm = 10'(imm); op_last = last;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (op_ready) acc = 1'b1;
      tick();
    end
    op_valid = 1'b0; op_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == done_snap && n < 40) begin tick(); n++; end
    chk("done_pulse", done_cnt - done_snap, 1);
    chk("idle_after_done", {30'd0, busy, op_ready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst = 1'b1; start = 0; base_addr = 0; op_valid = 0; op_last = 0;
    op_code = 0; op_rd = 0; op_rs = 0; op_rt = 0; op_imm = 0;
    repeat (3) tick();
    chk("reset_outputs", {imem_wdata[7:0], imem_addr, 9'd0, inst_count[6:0]}, 32'd0);
    chk("reset_flags", {27'd0, busy, done, err, op_ready, imem_we}, 32'd0);
    rst = 1'b0;
    tick();

    // Single ADDVI as last op
    do_start(8'h10);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_op(0, 3, 2, 0, 5, 1, acc);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    wait_done();
    chk("t1_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("t1_addr", {24'd0, wlog[0].addr}, 32'h10);
      chk("t1_word", wlog[0].data, 32'h040510C6);
    end
    chk("t1_count", {23'd0, inst_count}, 1);
    chk("t1_err", {31'd0, err}, 0);

    // Back-to-back stream
    do_start(8'h20);
    send_op(2, 1, 2, 0, 10'h3FF, 0, acc);
    send_op(3, 0, 5, 4, 0, 0, acc);
    send_op(4, 7, 0, 0, 10'h155, 0, acc);
    send_op(5, 1, 2, 3, 0, 1, acc);
    wait_done();
    chk("t2_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t2_w0", wlog[0].data, 32'h23FF1060);
      chk("t2_w1", wlog[1].data, 32'h20002924);
      chk("t2_w2", wlog[2].data, 32'h0B0AA9C0);
      chk("t2_w3", wlog[3].data, 32'h1003104E);
      for (int i = 1; i < 4; i++) begin
        chk("t2_addr_step", {24'd0, wlog[i].addr}, 32'h20 + i);
        chk("t2_cycle_step", wlog[i].cyc - wlog[i-1].cyc, 1);
      end
    end
    chk("t2_count", {23'd0, inst_count}, 4);

    // Illegal op mid-stream, plus a start pulse while busy
    do_start(8'h40);
    send_op(0, 1, 1, 0, 1, 0, acc);
    send_op(7, 2, 2, 2, 2, 0, acc);
    chk("t3_err_set", {31'd0, err}, 1);
    start = 1'b1; base_addr = 8'h80;
    tick();
    start = 1'b0;
    send_op(6, 4, 5, 6, 0, 1, acc);
    wait_done();
    chk("t3_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) chk("t3_addr1", {24'd0, wlog[1].addr}, 32'h41);
    chk("t3_err", {31'd0, err}, 1);
    chk("t3_count", {23'd0, inst_count}, 2);

    // Address wrap ends the session
    do_start(8'hFE);
    send_op(2, 1, 1, 0, 3, 0, acc);
    send_op(3, 0, 1, 2, 4, 0, acc);
    op_valid = 1'b1; op_code = 3'd4; op_rd = 5'd3; op_imm = 10'd9; op_last = 1'b0;
    wait_done();
    op_valid = 1'b0;
    chk("t4_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t4_addr0", {24'd0, wlog[0].addr}, 32'hFE);
      chk("t4_addr1", {24'd0, wlog[1].addr}, 32'hFF);
    end
    chk("t4_err", {31'd0, err}, 1);

    // Out-of-range 5-bit immediate
    do_start(8'h50);
    send_op(0, 2, 3, 0, 10'h025, 1, acc);
    wait_done();
`ifdef ENC_RANGE_CHECK_EN
    chk("t5_nwrites", wlog.size(), 0);
    chk("t5_err", {31'd0, err}, 1);
`else
    chk("t5_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) chk("t5_word", wlog[0].data, 32'h04051886);
    chk("t5_err", {31'd0, err}, 0);
`endif

    // Reset on the same edge an op is accepted
    do_start(8'h60);
    op_valid = 1'b1; op_code = 3'd5; op_rd = 1; op_rs = 2; op_rt = 3; op_last = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; op_valid = 1'b0;
    chk("t6_flags", {27'd0, busy, done, err, op_ready, imem_we}, 32'd0);
    chk("t6_addr", {24'd0, imem_addr}, 32'd0);
    do_start(8'h70);
    send_op(4, 9, 0, 0, 10'h2AA, 1, acc);
    wait_done();
    chk("t6_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) chk("t6_addr_after", {24'd0, wlog[0].addr}, 32'h70);

    // Randomized sessions, some starting near the top of memory
    for (int s = 0; s < 12; s++) begin
      int unsigned n;
      logic [7:0] b;
      b = (s % 3 == 0) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom);
      n = $urandom_range(3, 12);
      do_start(b);
      for (int k = 0; k < n; k++) begin
        send_op($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 1023), (k == n - 1), acc);
        if (!acc) break;
        if ($urandom_range(0, 3) == 0) tick();
      end
      wait_done();
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
